// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer and the DataMemory it fronts.
package store_buffer_pkg;

  localparam int unsigned AW_DEFAULT    = 32;
  localparam int unsigned DW_DEFAULT    = 32;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // DataMemory RW encoding, shared with the memory model.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/store_buffer_if.sv
// CPU load/store handshake plus the single DataMemory port.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
);

  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          empty;
  logic          RW;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;

  // CPU plus DataMemory side
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, DataOut,
    input  st_ready, ld_ready, ld_data, empty, RW, DAddr, DataIn
  );

  // Store buffer side
  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, DataOut,
    output st_ready, ld_ready, ld_data, empty, RW, DAddr, DataIn
  );

endinterface

// File: rtl/store_buffer_fifo_cam.sv
// Pending-store FIFO with an address CAM returning the youngest matching entry.
module sb_fifo_cam
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enq,
  input  logic [AW-1:0] i_enq_addr,
  input  logic [DW-1:0] i_enq_data,
  input  logic          i_deq,
  input  logic [AW-1:0] i_lookup_addr,
  output logic          o_hit,
  output logic [DW-1:0] o_hit_data,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];

  // Scan oldest to youngest so the last valid match (nearest tail) wins.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && (r_addr[PW'(r_head + PW'(k))] == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[PW'(r_head + PW'(k))];
      end
    end
  end

  // Entry storage, wrap-around pointers and occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (i_enq) begin
        r_addr[r_tail] <= i_enq_addr;
        r_data[r_tail] <= i_enq_data;
        r_tail         <= r_tail + PW'(1);
      end
      if (i_deq) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(i_enq) - CW'(i_deq);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write buffer in front of single-port DataMemory: forwards loads, drains stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input logic           CLK,
  input logic           Reset,
  store_buffer_if.slave bus
);

  logic          w_cam_hit;
  logic [DW-1:0] w_hit_data;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  logic          w_full;
  logic          w_empty;
  logic          w_enq;
  logic          w_hit;
  logic          w_load_port;
  logic          w_drain;

  sb_fifo_cam #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo_cam (
    .i_clk         (CLK),
    .i_rst         (Reset),
    .i_enq         (w_enq),
    .i_enq_addr    (bus.st_addr),
    .i_enq_data    (bus.st_data),
    .i_deq         (w_drain),
    .i_lookup_addr (bus.ld_addr),
    .o_hit         (w_cam_hit),
    .o_hit_data    (w_hit_data),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_full        (w_full),
    .o_empty       (w_empty)
  );

  // A load missing the buffer takes the port unless the buffer is full;
  // a drain otherwise uses the port, never during reset.
  assign w_enq       = bus.st_valid && !w_full;
  assign w_hit       = bus.ld_valid && w_cam_hit;
  assign w_load_port = bus.ld_valid && !w_cam_hit && !w_full;
  assign w_drain     = !Reset && !w_load_port && !w_empty;

  // Handshake and memory-port outputs from start-of-cycle state.
  always_comb begin
    bus.st_ready = !w_full;
    bus.empty    = w_empty;
    bus.ld_ready = w_hit || w_load_port;
    bus.ld_data  = '0;
    bus.RW       = MEM_READ;
    bus.DAddr    = '0;
    bus.DataIn   = '0;
    if (w_hit) begin
      bus.ld_data = w_hit_data;
    end else if (w_load_port) begin
      bus.ld_data = bus.DataOut;
    end
    if (w_load_port) begin
      bus.DAddr = bus.ld_addr;
    end else if (w_drain) begin
      bus.RW     = MEM_WRITE;
      bus.DAddr  = w_head_addr;
      bus.DataIn = w_head_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural DataMemory.
module tb_store_buffer;

  logic CLK;
  logic Reset;
  logic preload;
  logic [31:0] mem [256];
  int wr_bad;
  int n_cmp;
  int n_err;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DataMemory: combinational read, write on rising edge.
  assign bus.DataOut = mem[bus.DAddr[7:0]];

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h02] <= 32'h7;
      mem[8'h05] <= 32'h55;
      mem[8'h40] <= 32'h99;
      wr_bad <= 0;
    end else if (bus.RW == 1'b1) begin
      mem[bus.DAddr[7:0]] <= bus.DataIn;
      if (bus.DAddr >= 32'h30 && bus.DAddr <= 32'h32) wr_bad <= wr_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
    #2;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    Reset   = 1'b1;
    preload = 1'b1;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0;
    repeat (3) @(posedge CLK);
    #1;
    Reset   = 1'b0;
    preload = 1'b0;

    // Post-reset state
    drive(0, 0, 0, 0, 0);
    chk("rst_st_ready", 32'(bus.st_ready), 1);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_rw", 32'(bus.RW), 0);
    chk("rst_daddr", bus.DAddr, 0);
    chk("rst_datain", bus.DataIn, 0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 0);

    // Two stores drain on the following cycles
    drive(1, 32'h0, 32'h1, 0, 0);
    chk("t1_c0_rw", 32'(bus.RW), 0);
    cyc();
    drive(1, 32'h1, 32'h2, 0, 0);
    chk("t1_c1_rw", 32'(bus.RW), 1);
    chk("t1_c1_daddr", bus.DAddr, 32'h0);
    chk("t1_c1_datain", bus.DataIn, 32'h1);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("t1_c2_rw", 32'(bus.RW), 1);
    chk("t1_c2_daddr", bus.DAddr, 32'h1);
    chk("t1_c2_datain", bus.DataIn, 32'h2);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("t1_empty", 32'(bus.empty), 1);
    chk("t1_idle_rw", 32'(bus.RW), 0);

    // Duplicate address: youngest value forwarded and left in memory
    drive(1, 32'h1, 32'h2, 0, 0);
    cyc();
    drive(1, 32'h1, 32'h3, 0, 0);
    chk("t2_drain_old", bus.DataIn, 32'h2);
    cyc();
    drive(0, 0, 0, 1, 32'h1);
    chk("t2_ld_ready", 32'(bus.ld_ready), 1);
    chk("t2_ld_data", bus.ld_data, 32'h3);
    chk("t2_hit_drain_rw", 32'(bus.RW), 1);
    chk("t2_hit_drain_data", bus.DataIn, 32'h3);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("t2_empty", 32'(bus.empty), 1);
    chk("t2_mem1", mem[8'h01], 32'h3);

    // Missing load blocks drain while filling to DEPTH
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h10 + 32'(i), 32'hA0 + 32'(i), 1, 32'h40);
      chk("t3_fill_ld_ready", 32'(bus.ld_ready), 1);
      chk("t3_fill_ld_data", bus.ld_data, 32'h99);
      chk("t3_fill_rw", 32'(bus.RW), 0);
      chk("t3_fill_st_ready", 32'(bus.st_ready), 1);
      cyc();
    end
    drive(1, 32'h14, 32'hA4, 1, 32'h40);
    chk("t3_full_st_ready", 32'(bus.st_ready), 0);
    chk("t3_full_ld_ready", 32'(bus.ld_ready), 0);
    chk("t3_full_rw", 32'(bus.RW), 1);
    chk("t3_full_daddr", bus.DAddr, 32'h10);
    chk("t3_full_datain", bus.DataIn, 32'hA0);
    cyc();
    drive(1, 32'h14, 32'hA4, 1, 32'h40);
    chk("t3_after_st_ready", 32'(bus.st_ready), 1);
    chk("t3_after_ld_ready", 32'(bus.ld_ready), 1);
    chk("t3_after_ld_data", bus.ld_data, 32'h99);
    chk("t3_after_rw", 32'(bus.RW), 0);
    chk("t3_after_daddr", bus.DAddr, 32'h40);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("t3_drain_rw", 32'(bus.RW), 1);
      chk("t3_drain_daddr", bus.DAddr, 32'h11 + 32'(i));
      chk("t3_drain_datain", bus.DataIn, 32'hA1 + 32'(i));
      cyc();
    end
    drive(0, 0, 0, 0, 0);
    chk("t3_empty", 32'(bus.empty), 1);
    chk("t3_mem14", mem[8'h14], 32'hA4);

    // Load miss with two pending stores takes the port
    drive(1, 32'h20, 32'h5, 1, 32'h40);
    cyc();
    drive(1, 32'h21, 32'h6, 1, 32'h40);
    cyc();
    drive(0, 0, 0, 1, 32'h2);
    chk("t4_rw", 32'(bus.RW), 0);
    chk("t4_daddr", bus.DAddr, 32'h2);
    chk("t4_ld_ready", 32'(bus.ld_ready), 1);
    chk("t4_ld_data", bus.ld_data, 32'h7);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("t4_resume_rw", 32'(bus.RW), 1);
    chk("t4_resume_daddr", bus.DAddr, 32'h20);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("t4_second_daddr", bus.DAddr, 32'h21);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("t4_empty", 32'(bus.empty), 1);

    // Same-cycle store is not forwarded; visible next cycle
    drive(1, 32'h5, 32'h77, 1, 32'h5);
    chk("t5_same_ld_data", bus.ld_data, 32'h55);
    chk("t5_same_rw", 32'(bus.RW), 0);
    chk("t5_same_daddr", bus.DAddr, 32'h5);
    cyc();
    drive(0, 0, 0, 1, 32'h5);
    chk("t5_next_ld_ready", 32'(bus.ld_ready), 1);
    chk("t5_next_ld_data", bus.ld_data, 32'h77);
    chk("t5_next_rw", 32'(bus.RW), 1);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("t5_empty", 32'(bus.empty), 1);

    // Reset with three pending stores discards them
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h30 + 32'(i), 32'hC0 + 32'(i), 1, 32'h40);
      cyc();
    end
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("t6_pre_empty", 32'(bus.empty), 0);
    chk("t6_rst_rw", 32'(bus.RW), 0);
    cyc();
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("t6_empty", 32'(bus.empty), 1);
    chk("t6_rw", 32'(bus.RW), 0);
    chk("t6_st_ready", 32'(bus.st_ready), 1);
    repeat (4) cyc();
    chk("t6_no_writes", 32'(wr_bad), 0);
    chk("t6_mem30", mem[8'h30], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
